// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg -- shared types and helpers for the arbitrated channel mux.
//   slice_state_t : occupancy of the two-entry skid slice (EMPTY/ONE/FULL).
//   ARB_IDX_W()   : width of a binary port index for a given port count.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } slice_state_t;

  // Binary index width; never narrower than one bit.
  function automatic int ARB_IDX_W(input int ports);
    return (ports < 2) ? 1 : $clog2(ports);
  endfunction

endpackage

// File: rtl/axi_arb_skid.sv
// axi_arb_skid -- two-entry full-throughput register slice.
//   clk, rst  : clock, synchronous active-high reset
//   i_data    : payload of the beat being transferred (last flag in the MSB)
//   i_valid   : a transfer happens this cycle (already qualified by o_acc)
//   o_acc     : slice can accept a beat; registered, never depends on i_ready
//   o_data    : output register contents
//   o_valid   : output register holds a beat
//   i_ready   : downstream ready
// Option AXI_ARB_MUX_TMR_EN: state, output and skid registers are triplicated,
// majority voted before use, and every replica is rewritten from the voted
// next value each cycle so a single upset is scrubbed out after one clock.
module axi_arb_skid
  import axi_arb_pkg::*;
#(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_acc,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  slice_state_t w_state;
  slice_state_t w_state_nx;
  logic [W-1:0] w_out;
  logic [W-1:0] w_out_nx;
  logic [W-1:0] w_skid;
  logic [W-1:0] w_skid_nx;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    w_state_nx = w_state;
    w_out_nx   = w_out;
    w_skid_nx  = w_skid;
    case (w_state)
      ST_EMPTY: begin
        if (i_valid) begin
          w_out_nx   = i_data;
          w_state_nx = ST_ONE;
        end
      end
      ST_ONE: begin
        if (i_valid && i_ready) begin
          w_out_nx = i_data;
        end else if (i_valid) begin
          w_skid_nx  = i_data;
          w_state_nx = ST_FULL;
        end else if (i_ready) begin
          w_state_nx = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (i_ready) begin
          w_out_nx   = w_skid;
          w_state_nx = ST_ONE;
        end
      end
      // An illegal encoding (only reachable through an upset) recovers to EMPTY.
      default: w_state_nx = ST_EMPTY;
    endcase
  end

`ifdef AXI_ARB_MUX_TMR_EN
  logic [1:0]   w_state_rep [3];
  logic [W-1:0] w_out_rep   [3];
  logic [W-1:0] w_skid_rep  [3];
  logic [1:0]   w_state_v;

  for (genvar k = 0; k < 3; k++) begin : g_rep
    logic [1:0]   r_state;
    logic [W-1:0] r_out;
    logic [W-1:0] r_skid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= ST_EMPTY;
        r_out   <= '0;
        r_skid  <= '0;
      end else begin
        r_state <= w_state_nx;
        r_out   <= w_out_nx;
        r_skid  <= w_skid_nx;
      end
    end

    assign w_state_rep[k] = r_state;
    assign w_out_rep[k]   = r_out;
    assign w_skid_rep[k]  = r_skid;
  end

  axi_tmr_simple_voter #(.W(2)) u_vote_state (
    .i_a(w_state_rep[0]), .i_b(w_state_rep[1]), .i_c(w_state_rep[2]), .o_y(w_state_v)
  );
  axi_tmr_simple_voter #(.W(W)) u_vote_out (
    .i_a(w_out_rep[0]), .i_b(w_out_rep[1]), .i_c(w_out_rep[2]), .o_y(w_out)
  );
  axi_tmr_simple_voter #(.W(W)) u_vote_skid (
    .i_a(w_skid_rep[0]), .i_b(w_skid_rep[1]), .i_c(w_skid_rep[2]), .o_y(w_skid)
  );

  assign w_state = slice_state_t'(w_state_v);
`else
  slice_state_t r_state;
  logic [W-1:0] r_out;
  logic [W-1:0] r_skid;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= ST_EMPTY;
      // NOTE: the data registers are reset as well, because m_data must read
      // zero out of reset; they are plain flops, not a RAM.
      r_out   <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_out   <= w_out_nx;
      r_skid  <= w_skid_nx;
    end
  end

  assign w_state = r_state;
  assign w_out   = r_out;
  assign w_skid  = r_skid;
`endif

  assign o_acc   = (w_state != ST_FULL);
  assign o_valid = (w_state == ST_ONE) || (w_state == ST_FULL);
  assign o_data  = w_out;

endmodule

// File: rtl/axi_tmr_simple_voter.sv
// axi_tmr_simple_voter -- bitwise 2-of-3 majority voter.
//   W   : vector width
//   i_a, i_b, i_c : the three replicas
//   o_y : voted value
module axi_tmr_simple_voter #(
  parameter int W = 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_y
);

  assign o_y = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/axi_arb_mux.sv
// axi_arb_mux -- per-channel front end of the TMR-voted arbiter.
// Turns per-port valid/ready into the arbiter request vector, muxes the
// granted port (by encoded index) into a two-entry skid slice, pulses
// acknowledge on releasing transfers and flags inconsistent grants.
//   clk, rst      : clock, synchronous active-high reset
//   s_data/s_last/s_valid/s_ready : upstream ports (port i at [i*DATA_WIDTH +: DATA_WIDTH])
//   request, acknowledge          : to the arbiter
//   grant, grant_valid, grant_encoded : from the arbiter
//   m_data/m_last/m_valid/m_ready : downstream channel
//   grant_err     : sticky, grant one-hot disagrees with grant_encoded
// Option AXI_ARB_MUX_TMR_EN: triplicated, voted, scrubbed slice (see axi_arb_skid).
module axi_arb_mux
  import axi_arb_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int USE_LAST   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] s_data,
  input  logic [PORTS-1:0]            s_last,
  input  logic [PORTS-1:0]            s_valid,
  output logic [PORTS-1:0]            s_ready,
  output logic [PORTS-1:0]            request,
  output logic [PORTS-1:0]            acknowledge,
  input  logic [PORTS-1:0]            grant,
  input  logic                        grant_valid,
  input  logic [ARB_IDX_W(PORTS)-1:0] grant_encoded,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        grant_err
);

  localparam int IDX_W = ARB_IDX_W(PORTS);
  localparam int SW    = DATA_WIDTH + 1;

  logic [IDX_W-1:0]      w_sel;
  logic                  w_acc;
  logic [DATA_WIDTH-1:0] w_mux_data;
  logic                  w_mux_last;
  logic                  w_mux_valid;
  logic                  w_in_last;
  logic                  w_xfer;
  logic                  w_release;
  logic [PORTS-1:0]      w_onehot;
  logic [SW-1:0]         w_slice_out;
  logic                  r_grant_err;

  assign request = s_valid;
  assign w_sel   = grant_encoded;

  // Index compare instead of a variable part-select keeps an out-of-range
  // encoded index (non power-of-two PORTS) from selecting anything.
  always_comb begin
    w_mux_data  = '0;
    w_mux_last  = 1'b0;
    w_mux_valid = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (w_sel == IDX_W'(i)) begin
        w_mux_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_mux_last  = s_last[i];
        w_mux_valid = s_valid[i];
      end
    end
  end

  // Transfers are suppressed during reset so no partial ack escapes.
  assign w_xfer    = w_mux_valid & w_acc & grant_valid & ~rst;
  assign w_release = w_xfer & ((USE_LAST == 0) | w_mux_last);
  assign w_in_last = (USE_LAST != 0) ? w_mux_last : 1'b1;

  always_comb begin
    s_ready     = '0;
    acknowledge = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (w_sel == IDX_W'(i)) begin
        s_ready[i]     = w_acc & grant_valid & ~rst;
        acknowledge[i] = w_release;
      end
    end
  end

  axi_arb_skid #(.W(SW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_data  ({w_in_last, w_mux_data}),
    .i_valid (w_xfer),
    .o_acc   (w_acc),
    .o_data  (w_slice_out),
    .o_valid (m_valid),
    .i_ready (m_ready)
  );

  assign m_data = w_slice_out[DATA_WIDTH-1:0];
  assign m_last = w_slice_out[DATA_WIDTH];

  assign w_onehot = {{(PORTS-1){1'b0}}, 1'b1} << grant_encoded;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_err <= 1'b0;
    end else if (grant_valid && (grant != w_onehot)) begin
      r_grant_err <= 1'b1;
    end
  end

  assign grant_err = r_grant_err;

endmodule

// File: tb/tb_axi_arb_mux.sv
module tb_axi_arb_mux;

  localparam int P  = 4;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [P*DW-1:0] s_data;
  logic [P-1:0]  s_last, s_valid, grant;
  logic          grant_valid, m_ready;
  logic [1:0]    grant_encoded;

  logic [P-1:0]  s_ready0, request0, ack0;
  logic [DW-1:0] m_data0;
  logic          m_last0, m_valid0, gerr0;
  logic [P-1:0]  s_ready1, request1, ack1;
  logic [DW-1:0] m_data1;
  logic          m_last1, m_valid1, gerr1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_arb_mux #(.PORTS(P), .DATA_WIDTH(DW), .USE_LAST(0)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_last(s_last), .s_valid(s_valid),
    .s_ready(s_ready0), .request(request0), .acknowledge(ack0), .grant(grant),
    .grant_valid(grant_valid), .grant_encoded(grant_encoded), .m_data(m_data0),
    .m_last(m_last0), .m_valid(m_valid0), .m_ready(m_ready), .grant_err(gerr0)
  );

  axi_arb_mux #(.PORTS(P), .DATA_WIDTH(DW), .USE_LAST(1)) dut_l (
    .clk(clk), .rst(rst), .s_data(s_data), .s_last(s_last), .s_valid(s_valid),
    .s_ready(s_ready1), .request(request1), .acknowledge(ack1), .grant(grant),
    .grant_valid(grant_valid), .grant_encoded(grant_encoded), .m_data(m_data1),
    .m_last(m_last1), .m_valid(m_valid1), .m_ready(m_ready), .grant_err(gerr1)
  );

  typedef struct {
    logic [3:0] valid;
    logic [1:0] enc;
    logic       gv;
    logic       mrdy;
    logic [7:0] d;
    logic [3:0] e_rdy;
    logic [3:0] e_ack;
    logic       e_mv;
    int         e_port;
    logic [7:0] e_d;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [63:0] pdata(input int p, input logic [7:0] d);
    return {48'h0, 8'(p), d};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [1:0] e, input logic gv,
                       input logic mr, input logic [7:0] d, input logic [3:0] l);
    s_valid       = v;
    grant_encoded = e;
    grant         = 4'(1) << e;
    grant_valid   = gv;
    m_ready       = mr;
    s_last        = l;
    for (int i = 0; i < P; i++) s_data[i*DW +: DW] = pdata(i, d);
  endtask

`ifdef AXI_ARB_MUX_TMR_EN
  logic [DW:0] tmr_good, tmr_bad;
`endif

  initial begin
    //            valid    enc  gv mr  d      e_rdy    e_ack    mv port e_d
    vecs[0]  = '{4'b0100, 2'd2, 1, 1, 8'h11, 4'b0100, 4'b0100, 1, 2, 8'h11};
    vecs[1]  = '{4'b0000, 2'd2, 1, 1, 8'h12, 4'b0100, 4'b0000, 0, 0, 8'h00};
    vecs[2]  = '{4'b1000, 2'd3, 0, 1, 8'h13, 4'b0000, 4'b0000, 0, 0, 8'h00};
    vecs[3]  = '{4'b0001, 2'd3, 1, 1, 8'h14, 4'b1000, 4'b0000, 0, 0, 8'h00};
    vecs[4]  = '{4'b0010, 2'd1, 1, 0, 8'h21, 4'b0010, 4'b0010, 1, 1, 8'h21};
    vecs[5]  = '{4'b0010, 2'd1, 1, 0, 8'h22, 4'b0010, 4'b0010, 1, 1, 8'h21};
    vecs[6]  = '{4'b0010, 2'd1, 1, 0, 8'h23, 4'b0000, 4'b0000, 1, 1, 8'h21};
    vecs[7]  = '{4'b0010, 2'd1, 1, 1, 8'h23, 4'b0000, 4'b0000, 1, 1, 8'h22};
    vecs[8]  = '{4'b0010, 2'd1, 1, 1, 8'h23, 4'b0010, 4'b0010, 1, 1, 8'h23};
    vecs[9]  = '{4'b1000, 2'd3, 1, 1, 8'h31, 4'b1000, 4'b1000, 1, 3, 8'h31};
    vecs[10] = '{4'b1000, 2'd3, 1, 1, 8'h32, 4'b1000, 4'b1000, 1, 3, 8'h32};
    vecs[11] = '{4'b0001, 2'd0, 1, 1, 8'h41, 4'b0001, 4'b0001, 1, 0, 8'h41};
    vecs[12] = '{4'b0000, 2'd0, 1, 1, 8'h42, 4'b0001, 4'b0000, 0, 0, 8'h00};

    // Reset values, with a live request and grant present.
    rst = 1'b1;
    drive(4'b1010, 2'd1, 1'b1, 1'b1, 8'h01, 4'b0000);
    tick();
    tick();
    check("rst_m_valid", m_valid0, 0);
    check("rst_m_data", m_data0, 0);
    check("rst_m_last", m_last1, 0);
    check("rst_grant_err", gerr0, 0);
    #3;
    check("rst_s_ready", s_ready0, 0);
    check("rst_ack", ack0, 0);
    check("rst_request", request0, 4'b1010);
    tick();
    rst = 1'b0;
    drive(4'b0000, 2'd0, 1'b0, 1'b1, 8'h00, 4'b0000);
    tick();

    // Table-driven single-cycle vectors, USE_LAST=0 instance.
    for (int k = 0; k < 13; k++) begin
      drive(vecs[k].valid, vecs[k].enc, vecs[k].gv, vecs[k].mrdy, vecs[k].d, 4'b0000);
      #3;
      check($sformatf("v%0d_request", k), request0, vecs[k].valid);
      check($sformatf("v%0d_s_ready", k), s_ready0, vecs[k].e_rdy);
      check($sformatf("v%0d_ack", k), ack0, vecs[k].e_ack);
      tick();
      check($sformatf("v%0d_m_valid", k), m_valid0, vecs[k].e_mv);
      if (vecs[k].e_mv) begin
        check($sformatf("v%0d_m_data", k), m_data0, pdata(vecs[k].e_port, vecs[k].e_d));
        check($sformatf("v%0d_m_last", k), m_last0, 1);
      end
      check($sformatf("v%0d_grant_err", k), gerr0, 0);
    end

    // USE_LAST=1: 4-beat burst on port 1, ack only on the last beat.
    for (int b = 0; b < 4; b++) begin
      drive(4'b0010, 2'd1, 1'b1, 1'b1, 8'h50 + 8'(b), (b == 3) ? 4'b0010 : 4'b0000);
      #3;
      check($sformatf("burst%0d_s_ready", b), s_ready1, 4'b0010);
      check($sformatf("burst%0d_ack", b), ack1, (b == 3) ? 4'b0010 : 4'b0000);
      tick();
      check($sformatf("burst%0d_m_data", b), m_data1, pdata(1, 8'h50 + 8'(b)));
      check($sformatf("burst%0d_m_last", b), m_last1, (b == 3) ? 1 : 0);
    end
    drive(4'b0000, 2'd1, 1'b1, 1'b1, 8'h00, 4'b0000);
    tick();
    check("burst_drain_m_valid", m_valid1, 0);

    // Inconsistent grant: sticky error until reset.
    drive(4'b0000, 2'd2, 1'b1, 1'b1, 8'h00, 4'b0000);
    grant = 4'b0001;
    #3;
    check("gerr_before_edge", gerr0, 0);
    tick();
    check("gerr_set", gerr0, 1);
    grant = 4'b0100;
    tick();
    tick();
    check("gerr_sticky", gerr0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("gerr_cleared", gerr0, 0);

    // Reset while the slice is FULL.
    drive(4'b0001, 2'd0, 1'b1, 1'b0, 8'h61, 4'b0000);
    tick();
    drive(4'b0001, 2'd0, 1'b1, 1'b0, 8'h62, 4'b0000);
    tick();
    #3;
    check("full_s_ready", s_ready0, 0);
    check("full_m_valid", m_valid0, 1);
    tick();
    rst = 1'b1;
    #3;
    check("full_rst_ack", ack0, 0);
    tick();
    rst = 1'b0;
    check("full_rst_m_valid", m_valid0, 0);
    check("full_rst_m_data", m_data0, 0);
    drive(4'b0001, 2'd0, 1'b1, 1'b1, 8'h63, 4'b0000);
    #3;
    check("post_rst_ack", ack0, 4'b0001);
    tick();
    check("post_rst_m_valid", m_valid0, 1);
    check("post_rst_m_data", m_data0, pdata(0, 8'h63));
    drive(4'b0000, 2'd0, 1'b1, 1'b1, 8'h00, 4'b0000);
    tick();
    check("post_rst_drain", m_valid0, 0);

`ifdef AXI_ARB_MUX_TMR_EN
    // Upset one replica of the output register; the vote must mask it.
    drive(4'b0100, 2'd2, 1'b1, 1'b0, 8'h71, 4'b0000);
    tick();
    drive(4'b0000, 2'd2, 1'b1, 1'b0, 8'h00, 4'b0000);
    tmr_good = {1'b1, pdata(2, 8'h71)};
    tmr_bad  = tmr_good ^ 65'h1;
    force dut.u_skid.g_rep[1].r_out = tmr_bad;
    #1;
    check("tmr_masked", m_data0, pdata(2, 8'h71));
    release dut.u_skid.g_rep[1].r_out;
    tick();
    check("tmr_scrubbed", dut.u_skid.g_rep[1].r_out, tmr_good);
    check("tmr_m_data", m_data0, pdata(2, 8'h71));
    m_ready = 1'b1;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_arb_mux.md
# axi_arb_mux

Downstream consumer of the TMR-voted arbiter in the AXI interconnect. It turns per-port valid/ready channels (AW, AR or W) into the arbiter's `request` vector, forwards the granted port's payload through a full-throughput two-entry skid register slice, and returns a one-cycle `acknowledge` pulse to release the grant. It sits between the slave-side port buffers and the master-side channel register. It is instantiated once per arbitrated channel.

## Interface
- `PORTS`, default 4: number of upstream ports; must be ≥2.
- `DATA_WIDTH`, default 64: payload width per port.
- `USE_LAST`, default 0: 1 means grant is held until a beat with `s_last` set (W-channel bursts); 0 means every beat releases the grant.
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `s_data`, input, PORTS*DATA_WIDTH: port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_last`, input, PORTS: per-port last flag; ignored when USE_LAST=0.
- `s_valid`, input, PORTS: per-port valid.
- `s_ready`, output, PORTS: per-port ready.
- `request`, output, PORTS: request vector to the arbiter.
- `acknowledge`, output, PORTS: one-cycle release pulse to the arbiter.
- `grant`, input, PORTS: one-hot grant from the arbiter.
- `grant_valid`, input, 1: grant is valid.
- `grant_encoded`, input, $clog2(PORTS): binary index of the granted port.
- `m_data`, output, DATA_WIDTH: forwarded payload.
- `m_last`, output, 1: forwarded last flag. Tied to 1 when USE_LAST=0.
- `m_valid`, output, 1: master valid.
- `m_ready`, input, 1: master ready.
- `grant_err`, output, 1: sticky flag, set when `grant` ≠ (1 << `grant_encoded`) while `grant_valid` is 1.

## Operation
- `request` = `s_valid`, combinational and unmasked.
- `sel` = `grant_encoded`; the mux uses the encoded index only. `grant` is used only for the consistency check.
- Slice-ready `acc` = NOT `skid_valid` (registered). It never depends combinationally on `m_ready`.
- `s_ready[i]` = `acc` AND `grant_valid` AND (i == `sel`). Every other port sees 0.
- Transfer: `s_valid[sel]` AND `s_ready[sel]`.
- Two-entry slice, implemented as the `axi_arb_skid` sub-module. States:
  - EMPTY: `m_valid`=0. On transfer, go to ONE.
  - ONE: output register full. Transfer with `m_ready`=1 replaces the output register and stays in ONE. Transfer with `m_ready`=0 writes the skid register and goes to FULL. `m_ready`=1 with no transfer goes to EMPTY.
  - FULL: `acc`=0. On `m_ready`=1, the skid register moves to the output register and the state goes to ONE.
- `acknowledge[sel]` pulses 1 in the same cycle as a releasing transfer. A releasing transfer is any transfer when USE_LAST=0, or a transfer with `s_last[sel]`=1 when USE_LAST=1.
- At most one `acknowledge` bit is 1 in any cycle.
- If `grant_valid` is 1 but `s_valid[sel]` is 0, no transfer and no ack occur. The grant is simply held.
- The grant may change while the slice holds data. Captured data is unaffected.
- `grant_err` is set on any cycle where the one-hot check fails, and clears only on `rst`.

## Timing
- Latency from `s_valid` transfer to `m_valid`: 1 cycle.
- Throughput: 1 beat/cycle sustained while `m_ready`=1.
- Payload is held stable while `m_valid`=1 and `m_ready`=0. `m_valid` never drops without a handshake.
- Reset values: `m_valid`=0, `m_data`=0, `m_last`=0, `s_ready`=0, `acknowledge`=0, `grant_err`=0, slice EMPTY.
- `request` follows `s_valid` during reset.
- Reset asserted mid-transfer: slice contents are discarded. The next cycle shows all reset values. There is no partial ack.
- `acknowledge` and the transfer occur in the same cycle. The arbiter's new grant is seen on the following cycle at the earliest.

## Configuration
- `AXI_ARB_MUX_TMR_EN` defined: slice state, output register and skid register are each triplicated. Each triplicated set is bitwise-majority voted through `axi_tmr_simple_voter` before use and on outputs. Each replica is rewritten from the voted value every cycle (scrubbing).
- Undefined: single copy, no voters. Port-level behaviour and timing are identical.

## Structure
- Package `axi_arb_pkg`: slice state enum (EMPTY/ONE/FULL) and the `ARB_IDX_W(PORTS)` width helper constant function.
- Sub-module `axi_arb_skid`: the two-entry slice (DATA_WIDTH+1 bits wide), including the TMR option. The top level holds the mux, ready/ack decode and grant check.

## Test plan
- PORTS=4, grant_encoded=2, s_valid=4'b0100, m_ready=1 → data appears on m_data 1 cycle later; acknowledge=4'b0100 for exactly 1 cycle; s_ready[0,1,3]=0.
- m_ready=0 with 3 back-to-back beats → 2 accepted; s_ready drops on the 3rd; m_ready=1 → beats drain in order; no loss or duplication.
- USE_LAST=1, 4-beat burst on port 1 with s_last on beat 4 → acknowledge=4'b0010 only on beat 4; grant is held throughout.
- grant_valid=1, grant=4'b0001, grant_encoded=2 → grant_err=1 next cycle and sticky until rst.
- rst asserted in FULL state → m_valid=0, acknowledge=0 next cycle; the following transfer works normally.
- With AXI_ARB_MUX_TMR_EN, force one replica's data bit → m_data unchanged; the replica is corrected the next cycle.
